// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, winner codes and default tick counts for the pong controller
package pong_pkg;
  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } game_state_t;
  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam int SERVE_TICKS_DEF = 120;
  localparam int OVER_TICKS_DEF  = 180;
endpackage

// File: rtl/pong_tick_timer.sv
// pong_tick_timer: loadable frame-tick down-counter; load wins over tick, never underflows
module pong_tick_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             tick,
  output logic             done
);
  logic [TMR_W-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (tick && cnt != '0) cnt <= cnt - 1'b1;
  assign done = cnt == '0;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: new-game/play/serve/game-over sequencing, scoring and winner for two-player pong
module pong_game_ctrl import pong_pkg::*; #(
  parameter int WIN_SCORE   = 5,
  parameter int SERVE_TICKS = SERVE_TICKS_DEF,
  parameter int OVER_TICKS  = OVER_TICKS_DEF,
  parameter int TMR_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  input  logic       timer_tick,
  input  logic       pts_1,
  input  logic       pts_2,
  output logic       gra_still,
  output logic [1:0] game_state,
  output logic [3:0] score_1,
  output logic [3:0] score_2,
  output logic [1:0] winner
);
  localparam logic [3:0] WIN_M1 = 4'(WIN_SCORE - 1);
  game_state_t state;
  logic [3:0] btn_prev;
  logic start, done, load, p1_win, p2_win, win;
  assign start  = |(btn & ~btn_prev);
  assign p1_win = score_1 == WIN_M1;
  assign p2_win = score_2 == WIN_M1;
  // pts_1 has priority, so the win decision follows whichever point is taken
  assign win    = pts_1 ? p1_win : p2_win;
  assign load   = state == PLAY && (pts_1 || pts_2);
  pong_tick_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (win ? TMR_W'(OVER_TICKS) : TMR_W'(SERVE_TICKS)),
    .tick     (timer_tick && (state == NEWBALL || state == OVER)),
    .done     (done)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= NEWGAME;
      score_1  <= '0;
      score_2  <= '0;
      winner   <= WIN_NONE;
      btn_prev <= 4'hF;
    end else begin
      btn_prev <= btn;
      case (state)
        NEWGAME: if (start) state <= PLAY;
        PLAY:
          if (pts_1) begin
            score_1 <= score_1 + 4'd1;
            state   <= p1_win ? OVER : NEWBALL;
            if (p1_win) winner <= WIN_P1;
          end else if (pts_2) begin
            score_2 <= score_2 + 4'd1;
            state   <= p2_win ? OVER : NEWBALL;
            if (p2_win) winner <= WIN_P2;
          end
        NEWBALL: if (done) state <= PLAY;
        OVER:
          if (done) begin
            state   <= NEWGAME;
            score_1 <= '0;
            score_2 <= '0;
            winner  <= WIN_NONE;
          end
      endcase
    end
  assign game_state = state;
  assign gra_still  = state != PLAY;
endmodule
